// File: rtl/start_dispatch_pkg.sv
// Shared defaults for the start dispatch tracker.
// START_WATCHDOG_EN (optional) enables the per-unit watchdog in unit_busy_slot.
package start_dispatch_pkg;
  localparam int N_DEF       = 13;
  localparam int DEPTH_DEF   = 8;
  localparam int TIMEOUT_DEF = 1000;
  localparam int CW          = $clog2(DEPTH_DEF + 1);
  localparam int TW          = $clog2(TIMEOUT_DEF + 1);
endpackage

// File: rtl/start_dispatch_tracker_unit_busy_slot.sv
// One worker unit's busy bit; with START_WATCHDOG_EN also a watchdog counter
// that frees a unit which never reports done and flags the expiry.
module unit_busy_slot
  import start_dispatch_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic MHz10,
  input  logic nrst,
  input  logic set,
  input  logic done,
  input  logic clr_err,
  output logic busy,
  output logic timeout
);

`ifdef START_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);

  logic [WDW-1:0] age;
  logic           expire;

  // Expiry lands on the edge where the count would reach TIMEOUT.
  assign expire = busy && !set && !done && (age == WDW'(TIMEOUT - 1));

  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst) begin
      busy    <= 1'b0;
      age     <= '0;
      timeout <= 1'b0;
    end else begin
      if (set) begin
        busy <= 1'b1;
        age  <= '0;
      end else if (done || expire) begin
        busy <= 1'b0;
        age  <= '0;
      end else if (busy) begin
        age <= age + WDW'(1);
      end
      timeout <= expire | (timeout & ~clr_err);
    end
  end
`else
  logic unused;
  assign unused  = clr_err;
  assign timeout = 1'b0;

  // A grant on the same edge as done keeps the unit busy.
  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst) begin
      busy <= 1'b0;
    end else if (set) begin
      busy <= 1'b1;
    end else if (done) begin
      busy <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/start_dispatch_tracker.sv
// Queues job start requests, tracks busy workers and validates arbitrator grants.
// START_WATCHDOG_EN enables per-unit watchdog expiry via unit_busy_slot.
module start_dispatch_tracker
  import start_dispatch_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                         MHz10,
  input  logic                         nrst,
  input  logic                         req,
  input  logic [N-1:0]                 grant,
  input  logic [N-1:0]                 done,
  input  logic                         clr_err,
  output logic [N-1:0]                 avail,
  output logic                         start_in,
  output logic [$clog2(DEPTH+1)-1:0]   pending,
  output logic                         overflow,
  output logic                         proto_err,
  output logic [N-1:0]                 timeout
);

  localparam int PW = $clog2(DEPTH + 1);

  logic [N-1:0] busy;
  logic [N-1:0] acc;
  logic         multi;
  logic         hit_busy;
  logic         illegal;
  logic         issue;
  logic         ovf_evt;

  // start_in looks only at registered state, never at grant.
  assign avail    = ~busy;
  assign start_in = (pending != '0) && (|avail);

  assign multi    = (grant & (grant - N'(1))) != '0;
  assign hit_busy = |(grant & busy);
  assign illegal  = (grant != '0) && (multi || hit_busy || !start_in);
  assign issue    = (grant != '0) && !illegal;
  assign acc      = issue ? grant : '0;
  assign ovf_evt  = req && !issue && (pending == PW'(DEPTH));

  for (genvar i = 0; i < N; i++) begin : g_slot
    unit_busy_slot #(.TIMEOUT(TIMEOUT)) u_slot (
      .MHz10   (MHz10),
      .nrst    (nrst),
      .set     (acc[i]),
      .done    (done[i]),
      .clr_err (clr_err),
      .busy    (busy[i]),
      .timeout (timeout[i])
    );
  end

  // A new error event outranks clr_err on the same edge.
  always_ff @(posedge MHz10 or negedge nrst) begin
    if (!nrst) begin
      pending   <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (req && !issue && !ovf_evt) begin
        pending <= pending + PW'(1);
      end else if (issue && !req) begin
        pending <= pending - PW'(1);
      end
      overflow  <= ovf_evt | (overflow & ~clr_err);
      proto_err <= illegal | (proto_err & ~clr_err);
    end
  end

endmodule

// File: tb/tb_start_dispatch_tracker.sv
// Self-checking bench for start_dispatch_tracker: directed scenarios plus
// randomized traffic against a per-unit behavioural model (START_WATCHDOG_EN aware).
module tb_start_dispatch_tracker;
  import start_dispatch_pkg::*;

  localparam int N     = 13;
  localparam int DEPTH = 8;
`ifdef START_WATCHDOG_EN
  localparam int TO = 10;
  localparam bit WD = 1'b1;
`else
  localparam int TO = 1000;
  localparam bit WD = 1'b0;
`endif

  logic         MHz10 = 1'b0;
  logic         nrst = 1'b0;
  logic         req = 1'b0;
  logic         clr_err = 1'b0;
  logic [N-1:0] grant = '0;
  logic [N-1:0] done = '0;
  logic [N-1:0] avail;
  logic         start_in;
  logic [3:0]   pending;
  logic         overflow;
  logic         proto_err;
  logic [N-1:0] timeout;

  always #5 MHz10 = ~MHz10;

  start_dispatch_tracker #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .MHz10     (MHz10),
    .nrst      (nrst),
    .req       (req),
    .grant     (grant),
    .done      (done),
    .clr_err   (clr_err),
    .avail     (avail),
    .start_in  (start_in),
    .pending   (pending),
    .overflow  (overflow),
    .proto_err (proto_err),
    .timeout   (timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: one entry per worker plus a plain integer queue depth.
  bit m_busy [N];
  int m_age  [N];
  bit m_tmo  [N];
  int m_pend;
  bit m_ovf;
  bit m_perr;

  function automatic bit m_start();
    if (m_pend == 0) return 1'b0;
    for (int i = 0; i < N; i++) if (!m_busy[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_avail();
    logic [31:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = !m_busy[i];
    return v;
  endfunction

  function automatic logic [31:0] m_tvec();
    logic [31:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_tmo[i];
    return v;
  endfunction

  // Lowest idle unit, the way a simple arbitrator would answer start_in.
  function automatic logic [N-1:0] arb();
    if (!m_start()) return '0;
    for (int i = 0; i < N; i++) if (!m_busy[i]) return N'(1) << i;
    return '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 1'b0;
      m_age[i]  = 0;
      m_tmo[i]  = 1'b0;
    end
    m_pend = 0;
    m_ovf  = 1'b0;
    m_perr = 1'b0;
  endtask

  task automatic model_edge(bit r, logic [N-1:0] g, logic [N-1:0] d, bit c);
    int ones = 0;
    int idx  = 0;
    bit st, bad, iss, ovf_evt, expd;
    st = m_start();
    for (int i = 0; i < N; i++) if (g[i]) begin ones++; idx = i; end
    bad = (ones > 1) || (ones == 1 && m_busy[idx]) || (ones > 0 && !st);
    iss = (ones == 1) && !bad;
    for (int i = 0; i < N; i++) begin
      expd = 1'b0;
      if (iss && idx == i) begin
        m_busy[i] = 1'b1; m_age[i] = 0;
      end else if (d[i]) begin
        m_busy[i] = 1'b0; m_age[i] = 0;
      end else if (WD && m_busy[i]) begin
        m_age[i]++;
        if (m_age[i] == TO) begin
          m_busy[i] = 1'b0; m_age[i] = 0; expd = 1'b1;
        end
      end
      m_tmo[i] = expd || (m_tmo[i] && !c);
    end
    ovf_evt = 1'b0;
    if (r && !iss) begin
      if (m_pend == DEPTH) ovf_evt = 1'b1;
      else m_pend++;
    end else if (iss && !r) begin
      m_pend--;
    end
    m_ovf  = ovf_evt || (m_ovf && !c);
    m_perr = bad || (m_perr && !c);
  endtask

  task automatic check_state();
    check("avail",     32'(avail),     m_avail());
    check("pending",   32'(pending),   32'(m_pend));
    check("start_in",  32'(start_in),  32'(m_start()));
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("proto_err", 32'(proto_err), 32'(m_perr));
    check("timeout",   32'(timeout),   m_tvec());
  endtask

  // Called just after a rising edge; leaves time just after the next one.
  task automatic cycle(bit r, logic [N-1:0] g, logic [N-1:0] d, bit c);
    req = r; grant = g; done = d; clr_err = c;
    #3;
    check("start_in_pre", 32'(start_in), 32'(m_start()));
    @(posedge MHz10);
    model_edge(r, g, d, c);
    #1;
    req = 1'b0; grant = '0; done = '0; clr_err = 1'b0;
    check_state();
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    req = 1'b0; grant = '0; done = '0; clr_err = 1'b0;
    model_reset();
    #1;
    check_state();
    @(posedge MHz10);
    #1;
    nrst = 1'b1;
    check_state();
  endtask

  initial begin
    logic [N-1:0] g, d;
    logic [N-1:0] av;
    bit           r, c;
    int           p, rq_pct;

    model_reset();
    @(posedge MHz10);
    #1;
    do_reset();
    check("rst_avail",   32'(avail),    32'h1FFF);
    check("rst_pending", 32'(pending),  32'h0);
    check("rst_start",   32'(start_in), 32'h0);

    // Single request, grant, completion.
    cycle(1, '0, '0, 0);
    cycle(0, 13'h0001, '0, 0);
    check("t2_avail", 32'(avail), 32'h1FFE);
    check("t2_pend",  32'(pending), 32'h0);
    cycle(0, '0, 13'h0001, 0);
    check("t2_done", 32'(avail), 32'h1FFF);

    // Fill every unit, then overfill the queue.
    do_reset();
    for (int i = 0; i < N; i++) begin
      cycle(1, '0, '0, 0);
      cycle(0, arb(), '0, 0);
    end
    for (int k = 1; k <= 9; k++) begin
      cycle(1, '0, '0, 0);
`ifndef START_WATCHDOG_EN
      if (k == 8) begin
        check("t3_pend8", 32'(pending), 32'd8);
        check("t3_ovf0",  32'(overflow), 32'd0);
      end
`endif
    end
`ifndef START_WATCHDOG_EN
    check("t3_ovf1", 32'(overflow), 32'd1);
    check("t3_pend", 32'(pending), 32'd8);
`endif
    cycle(0, '0, 13'h0020, 0);
`ifndef START_WATCHDOG_EN
    check("t3_start", 32'(start_in), 32'd1);
`endif
    cycle(0, arb(), '0, 0);
`ifndef START_WATCHDOG_EN
    check("t3_pend7", 32'(pending), 32'd7);
    check("t3_full",  32'(avail), 32'd0);
`endif

    // Simultaneous req and issue; done/grant collision on one unit.
    cycle(0, '0, '1, 1);
    for (int k = 0; k < 4; k++) cycle(0, arb(), '0, 0);
    cycle(1, arb(), '0, 0);
`ifndef START_WATCHDOG_EN
    check("t4_pend3", 32'(pending), 32'd3);
`endif
    cycle(0, '0, 13'h0004, 0);
    cycle(0, 13'h0004, 13'h0004, 0);
    check("t4_u2busy", 32'(avail[2]), 32'd0);

    // Illegal grants and error clearing.
    av = avail;
    cycle(0, 13'h0003, '0, 0);
    check("t5_perr", 32'(proto_err), 32'd1);
    check("t5_avail", 32'(avail), 32'(av));
    cycle(0, '0, '0, 1);
    check("t5_clr", 32'(proto_err), 32'd0);
    cycle(0, 13'h0004, '0, 0);
    check("t5_busy_grant", 32'(proto_err), 32'd1);
    cycle(0, 13'h0003, '0, 1);
    check("t5_clr_prio", 32'(proto_err), 32'd1);
    cycle(0, '0, '0, 1);

`ifdef START_WATCHDOG_EN
    do_reset();
    cycle(1, '0, '0, 0);
    cycle(0, arb(), '0, 0);
    for (int k = 0; k < 9; k++) cycle(0, '0, '0, 0);
    check("t6_still_busy", 32'(avail[0]), 32'd0);
    cycle(0, '0, '0, 0);
    check("t6_freed", 32'(avail[0]), 32'd1);
    check("t6_tmo", 32'(timeout[0]), 32'd1);
`else
    check("t6_no_tmo", 32'(timeout), 32'd0);
`endif

    // Randomized traffic with occasional asynchronous resets.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 599) == 0) begin
        #2;
        do_reset();
      end else begin
        case ((cyc / 300) % 3)
          0:       rq_pct = 30;
          1:       rq_pct = 80;
          default: rq_pct = 50;
        endcase
        r = ($urandom_range(0, 99) < rq_pct);
        p = $urandom_range(0, 9);
        if (p < 6)       g = arb();
        else if (p == 6) g = N'($urandom);
        else if (p == 7) g = N'(1) << $urandom_range(0, N - 1);
        else             g = '0;
        d = '0;
        for (int i = 0; i < N; i++)
          if (m_busy[i] && $urandom_range(0, 15) == 0) d[i] = 1'b1;
        if ($urandom_range(0, 19) == 0) d[$urandom_range(0, N - 1)] = 1'b1;
        c = ($urandom_range(0, 19) == 0);
        cycle(r, g, d, c);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
